instruction_decode: RTL and testbench

//   Control decoder of the single-cycle 16-bit RISC core. Decodes Instruction[15:11] (plus cond/funct fields)
//   and flags C/Z into datapath selects and enables, combinationally in the same cycle. One sticky halt register
//   (clocked) holds the machine stopped after HLT until reset.

---
 rtl/instruction_decode.sv | 91 +++++++++
 tb/tb_instruction_decode.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/instruction_decode.sv
// instruction_decode: single-cycle control decoder with a sticky halt register
module instruction_decode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] Instruction,
    input  logic        C,
    input  logic        Z,
    output logic        flag_HLT,
    output logic        data_write_en,
    output logic        flag_label_PC,
    output logic        flag_Rm_PC,
    output logic        flag_Rd_PC,
    output logic        BRANCH,
    output logic        ADC,
    output logic        SUB,
    output logic        SBB,
    output logic        JMP,
    output logic        Src_ALU_B,
    output logic        Src_Read_B,
    output logic        flag_mem_RF,
    output logic        flag_ALU_RF,
    output logic        flag_Rm_RF,
    output logic        flag_PC_RF,
    output logic        LHI,
    output logic        LLI,
    output logic        RF_write_en,
    output logic        flag_OutR
);
    logic [4:0] op;
    logic [3:0] cond;
    logic [1:0] funct;
    logic       halt_q, run, taken;
    logic       alu, lhi, lli, ldr, str, cmp, addi, subi, mov, br, jmp, jal1, jal2, jr, sys;
    logic       hlt_dec;
    logic       unused_bits;
    assign op          = Instruction[15:11];
    assign cond        = Instruction[11:8];
    assign funct       = Instruction[1:0];
    assign unused_bits = ^Instruction[7:2];
    assign run         = ~halt_q;
    assign alu  = op == 5'b00000;
    assign lhi  = op == 5'b00001;
    assign lli  = op == 5'b00010;
    assign ldr  = op == 5'b00011;
    assign str  = op == 5'b00101;
    assign cmp  = op == 5'b00110;
    assign addi = op == 5'b00111;
    assign subi = op == 5'b01000;
    assign mov  = op == 5'b01011;
    assign br   = op[4:1] == 4'b1100;
    assign jmp  = op == 5'b10000;
    assign jal1 = op == 5'b10001;
    assign jal2 = op == 5'b10010;
    assign jr   = op == 5'b10011;
    assign sys  = op == 5'b11100;
    assign hlt_dec = sys & (funct == 2'b01);
    // Branch condition evaluation against the ALU flags; unlisted conditions never take
    always_comb
        taken = br & (cond == 4'h0 ? Z :
                      cond == 4'h1 ? ~Z :
                      cond == 4'h2 ? C :
                      cond == 4'h3 ? ~C :
                      cond == 4'hE);
    // Sticky halt: set by an executed HLT, released only by reset
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            halt_q <= 1'b0;
        else if (hlt_dec)
            halt_q <= 1'b1;
    assign flag_HLT      = hlt_dec | halt_q;
    assign ADC           = alu & (funct == 2'b01);
    assign SUB           = (alu & (funct == 2'b10)) | cmp | subi;
    assign SBB           = alu & (funct == 2'b11);
    assign JMP           = jmp;
    assign Src_ALU_B     = ldr | str | addi | subi;
    assign Src_Read_B    = str | jr;
    assign flag_mem_RF   = ldr;
    assign flag_ALU_RF   = alu | addi | subi;
    assign flag_Rm_RF    = mov;
    assign flag_PC_RF    = jal1 | jal2;
    assign LHI           = lhi;
    assign LLI           = lli;
    // State-changing outputs are suppressed while the machine is halted
    assign RF_write_en   = run & (alu | lhi | lli | ldr | addi | subi | mov | jal1 | jal2);
    assign data_write_en = run & str;
    assign flag_OutR     = run & sys & (funct == 2'b00);
    assign BRANCH        = run & taken;
    assign flag_label_PC = run & (taken | jmp | jal1);
    assign flag_Rm_PC    = run & jal2;
    assign flag_Rd_PC    = run & jr;
endmodule

// File: tb/tb_instruction_decode.sv
// tb_instruction_decode: directed-vector check of the control decoder and halt behaviour
module tb_instruction_decode;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] Instruction = 16'h0000;
    logic        C = 1'b0;
    logic        Z = 1'b0;
    logic flag_HLT, data_write_en, flag_label_PC, flag_Rm_PC, flag_Rd_PC, BRANCH;
    logic ADC, SUB, SBB, JMP, Src_ALU_B, Src_Read_B;
    logic flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF, LHI, LLI, RF_write_en, flag_OutR;
    int tests = 0;
    int fails = 0;

    localparam logic [19:0] M_HLT  = 20'h80000;
    localparam logic [19:0] M_DWE  = 20'h40000;
    localparam logic [19:0] M_LPC  = 20'h20000;
    localparam logic [19:0] M_RMPC = 20'h10000;
    localparam logic [19:0] M_RDPC = 20'h08000;
    localparam logic [19:0] M_BR   = 20'h04000;
    localparam logic [19:0] M_ADC  = 20'h02000;
    localparam logic [19:0] M_SUB  = 20'h01000;
    localparam logic [19:0] M_SBB  = 20'h00800;
    localparam logic [19:0] M_JMP  = 20'h00400;
    localparam logic [19:0] M_SAB  = 20'h00200;
    localparam logic [19:0] M_SRB  = 20'h00100;
    localparam logic [19:0] M_MEM  = 20'h00080;
    localparam logic [19:0] M_ALU  = 20'h00040;
    localparam logic [19:0] M_RMRF = 20'h00020;
    localparam logic [19:0] M_PCRF = 20'h00010;
    localparam logic [19:0] M_LHI  = 20'h00008;
    localparam logic [19:0] M_LLI  = 20'h00004;
    localparam logic [19:0] M_RFW  = 20'h00002;
    localparam logic [19:0] M_OUT  = 20'h00001;

    logic [19:0] outs;
    assign outs = {flag_HLT, data_write_en, flag_label_PC, flag_Rm_PC, flag_Rd_PC, BRANCH,
                   ADC, SUB, SBB, JMP, Src_ALU_B, Src_Read_B,
                   flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF, LHI, LLI, RF_write_en, flag_OutR};

    instruction_decode dut (
        .clk(clk), .rst_n(rst_n), .Instruction(Instruction), .C(C), .Z(Z),
        .flag_HLT(flag_HLT), .data_write_en(data_write_en), .flag_label_PC(flag_label_PC),
        .flag_Rm_PC(flag_Rm_PC), .flag_Rd_PC(flag_Rd_PC), .BRANCH(BRANCH),
        .ADC(ADC), .SUB(SUB), .SBB(SBB), .JMP(JMP), .Src_ALU_B(Src_ALU_B), .Src_Read_B(Src_Read_B),
        .flag_mem_RF(flag_mem_RF), .flag_ALU_RF(flag_ALU_RF), .flag_Rm_RF(flag_Rm_RF),
        .flag_PC_RF(flag_PC_RF), .LHI(LHI), .LLI(LLI), .RF_write_en(RF_write_en), .flag_OutR(flag_OutR)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    typedef struct {
        string       tag;
        logic [15:0] instr;
        logic [15:0] mask;
        logic        c;
        logic        z;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic apply(input logic [15:0] instr, input logic c, input logic z);
        @(negedge clk);
        Instruction = instr;
        C = c;
        Z = z;
        #2;
    endtask

    initial begin
        vecs = '{
            '{"ADD",   16'h0000, 16'hF803, 1'b0, 1'b0, M_RFW | M_ALU},
            '{"ADC",   16'h0001, 16'hF803, 1'b0, 1'b0, M_RFW | M_ALU | M_ADC},
            '{"SUB",   16'h0002, 16'hF803, 1'b0, 1'b0, M_RFW | M_ALU | M_SUB},
            '{"SBB",   16'h0003, 16'hF803, 1'b0, 1'b0, M_RFW | M_ALU | M_SBB},
            '{"LHI",   16'h0800, 16'hF800, 1'b0, 1'b0, M_LHI | M_RFW},
            '{"LLI",   16'h1000, 16'hF800, 1'b0, 1'b0, M_LLI | M_RFW},
            '{"LDR",   16'h1800, 16'hF800, 1'b0, 1'b0, M_RFW | M_MEM | M_SAB},
            '{"STR",   16'h2800, 16'hF800, 1'b0, 1'b0, M_DWE | M_SAB | M_SRB},
            '{"CMP",   16'h3003, 16'hF800, 1'b0, 1'b0, M_SUB},
            '{"ADDI",  16'h3800, 16'hF800, 1'b0, 1'b0, M_RFW | M_ALU | M_SAB},
            '{"SUBI",  16'h4000, 16'hF800, 1'b0, 1'b0, M_RFW | M_ALU | M_SAB | M_SUB},
            '{"MOV",   16'h5800, 16'hF800, 1'b0, 1'b0, M_RFW | M_RMRF},
            '{"BEQnt", 16'hC000, 16'hFF00, 1'b1, 1'b0, 20'h0},
            '{"BEQt",  16'hC000, 16'hFF00, 1'b0, 1'b1, M_BR | M_LPC},
            '{"BNEt",  16'hC100, 16'hFF00, 1'b0, 1'b0, M_BR | M_LPC},
            '{"BNEnt", 16'hC100, 16'hFF00, 1'b0, 1'b1, 20'h0},
            '{"BCSt",  16'hC200, 16'hFF00, 1'b1, 1'b0, M_BR | M_LPC},
            '{"BCSnt", 16'hC200, 16'hFF00, 1'b0, 1'b1, 20'h0},
            '{"BCCt",  16'hC300, 16'hFF00, 1'b0, 1'b0, M_BR | M_LPC},
            '{"BCCnt", 16'hC300, 16'hFF00, 1'b1, 1'b0, 20'h0},
            '{"B",     16'hCE00, 16'hFF00, 1'b1, 1'b1, M_BR | M_LPC},
            '{"Bnev5", 16'hC500, 16'hFF00, 1'b1, 1'b1, 20'h0},
            '{"Bnev8", 16'hC800, 16'hFF00, 1'b0, 1'b1, 20'h0},
            '{"JMP",   16'h8000, 16'hF800, 1'b0, 1'b0, M_JMP | M_LPC},
            '{"JAL1",  16'h8800, 16'hF800, 1'b0, 1'b0, M_LPC | M_PCRF | M_RFW},
            '{"JAL2",  16'h9000, 16'hF800, 1'b0, 1'b0, M_RMPC | M_PCRF | M_RFW},
            '{"JR",    16'h9800, 16'hF800, 1'b0, 1'b0, M_RDPC | M_SRB},
            '{"OUTR",  16'hE000, 16'hF803, 1'b0, 1'b0, M_OUT},
            '{"HLTd",  16'hE001, 16'hF803, 1'b0, 1'b0, M_HLT},
            '{"NOP2",  16'hE002, 16'hF803, 1'b0, 1'b0, 20'h0},
            '{"NOP3",  16'hE003, 16'hF803, 1'b0, 1'b0, 20'h0},
            '{"OP04",  16'h2000, 16'hF800, 1'b0, 1'b0, 20'h0},
            '{"OP1F",  16'hF800, 16'hF800, 1'b0, 1'b0, 20'h0}
        };

        #2;
        check("reset_decode", outs, M_RFW | M_ALU);
        @(negedge clk);
        rst_n = 1'b1;

        // The HLT vector is applied only between edges here; clear it before the next edge
        foreach (vecs[i]) begin
            apply(vecs[i].instr, vecs[i].c, vecs[i].z);
            check(vecs[i].tag, outs, vecs[i].exp);
            Instruction = 16'h0000;
        end
        apply(16'h0000, 1'b0, 1'b0);
        check("no_halt_leak", outs, M_RFW | M_ALU);

        // Don't-care bits filled with random data must not change the decode
        for (int r = 0; r < 3; r++)
            foreach (vecs[i]) begin
                @(negedge clk);
                Instruction = (vecs[i].instr & vecs[i].mask) | (16'($urandom) & ~vecs[i].mask);
                C = vecs[i].c;
                Z = vecs[i].z;
                #2;
                check({vecs[i].tag, "_rnd"}, outs, vecs[i].exp);
                Instruction = 16'h0000;
            end

        apply(16'hE001, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        Instruction = 16'h0000;
        #1;
        check("halt_add", outs, M_HLT | M_ALU);
        apply(16'hCE00, 1'b1, 1'b1);
        check("halt_branch", outs, M_HLT);
        apply(16'h8800, 1'b0, 1'b0);
        check("halt_jal1", outs, M_HLT | M_PCRF);
        apply(16'h2800, 1'b0, 1'b0);
        check("halt_str", outs, M_HLT | M_SAB | M_SRB);
        apply(16'hE000, 1'b0, 1'b0);
        check("halt_outr", outs, M_HLT);
        apply(16'h9800, 1'b0, 1'b0);
        check("halt_jr", outs, M_HLT | M_SRB);
        apply(16'h0000, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("halt_sticky", outs, M_HLT | M_ALU);

        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", outs, M_RFW | M_ALU);
        @(negedge clk);
        rst_n = 1'b1;
        apply(16'h9000, 1'b0, 1'b0);
        check("post_reset_jal2", outs, M_RMPC | M_PCRF | M_RFW);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
